// File: rtl/inst_queue_pkg.sv
// Shared widths, queue entry layout and fetch FSM encoding for the instruction queue.
package inst_queue_pkg;

    localparam int InstWidth = 32;
    localparam int AddrWidth = 32;

    localparam logic [AddrWidth-1:0] InstBytes = AddrWidth'(4);

    typedef struct packed {
        logic [InstWidth-1:0] inst;
        logic [AddrWidth-1:0] pc;
    } iq_entry_t;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fifo.sv
// Circular buffer of {inst, pc} with push/pop/clear, occupancy count and full/empty.
// Latency: head read is combinational; push/pop take effect at the next edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module inst_fifo
    import inst_queue_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PtrW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  iq_entry_t       push_dat,
    input  logic            pop,
    output iq_entry_t       head_dat,
    output logic [PtrW:0]   count,
    output logic            full,
    output logic            empty
);

    localparam logic [PtrW:0] FullCount = (PtrW+1)'(DEPTH);

    iq_entry_t         mem [DEPTH];
    logic [PtrW-1:0]   head;
    logic [PtrW-1:0]   tail;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FullCount);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = empty ? '0 : mem[head];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; empty gating keeps stale words off the head outputs.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear) mem[tail] <= push_dat;
    end

endmodule

// File: rtl/inst_queue.sv
// Fetch front end: issues one ICache request at a time and queues returned words for decode.
// Latency: head combinational from the queue; request issued the cycle after a slot frees up.
// Backpressure: no request while full or rdy=0; a slot is reserved per request so pushes never stall.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int                   DEPTH    = 16,
    parameter logic [AddrWidth-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    output logic                 ic_req,
    output logic [AddrWidth-1:0] ic_addr,
    input  logic                 ic_valid,
    input  logic [InstWidth-1:0] ic_inst,
    output logic                 IQ_inst_valid,
    output logic [InstWidth-1:0] IQ_inst,
    output logic [AddrWidth-1:0] IQ_pc,
    input  logic                 IQ_pop,
    input  logic                 flush,
    input  logic [AddrWidth-1:0] flush_pc
);

    localparam int PtrW = $clog2(DEPTH);

    fetch_state_t         state;
    fetch_state_t         state_nxt;
    logic [AddrWidth-1:0] fetch_pc;
    logic                 flush_act;
    logic                 push;
    logic                 pop;
    iq_entry_t            push_dat;
    iq_entry_t            head_dat;
    logic [PtrW:0]        fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    // A frozen pipeline ignores redirects, but responses in flight are still absorbed.
    assign flush_act = rdy && flush;
    assign push      = (state == FETCH_WAIT) && ic_valid && !flush_act;
    assign pop       = rdy && IQ_pop && !fifo_empty && !flush_act;
    assign push_dat  = '{inst: ic_inst, pc: fetch_pc};

    assign ic_req  = (state == FETCH_IDLE) && rdy && !flush && !fifo_full && !rst;
    assign ic_addr = (ic_req || state == FETCH_WAIT) ? fetch_pc : '0;

    assign IQ_inst_valid = (fifo_count != '0);
    assign IQ_inst       = head_dat.inst;
    assign IQ_pc         = head_dat.pc;

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_IDLE: if (ic_req) state_nxt = FETCH_WAIT;
            FETCH_WAIT: begin
                if (ic_valid)       state_nxt = FETCH_IDLE;
                else if (flush_act) state_nxt = FETCH_DROP;
            end
            FETCH_DROP: if (ic_valid) state_nxt = FETCH_IDLE;
            default:    state_nxt = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (flush_act)  fetch_pc <= flush_pc;
            else if (push)  fetch_pc <= fetch_pc + InstBytes;
        end
    end

    inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush_act),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed vector table, steady-stream check, randomized model comparison.
module tb_inst_queue;

    localparam int          DEPTH    = 16;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_inst;
    logic        IQ_inst_valid;
    logic [31:0] IQ_inst;
    logic [31:0] IQ_pc;
    logic        IQ_pop;
    logic        flush;
    logic [31:0] flush_pc;

    inst_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .ic_req        (ic_req),
        .ic_addr       (ic_addr),
        .ic_valid      (ic_valid),
        .ic_inst       (ic_inst),
        .IQ_inst_valid (IQ_inst_valid),
        .IQ_inst       (IQ_inst),
        .IQ_pc         (IQ_pc),
        .IQ_pop        (IQ_pop),
        .flush         (flush),
        .flush_pc      (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          rst, rdy, iv;
        logic [31:0] inst;
        bit          pop, fl;
        logic [31:0] fpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_vld;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    vec_t tbl[$];

    function automatic void row(bit r, bit rd, bit iv, logic [31:0] ii, bit p, bit fl,
                                logic [31:0] fp, bit er, logic [31:0] ea, bit ev, logic [31:0] ep);
        vec_t v;
        v = '{rst: r, rdy: rd, iv: iv, inst: ii, pop: p, fl: fl, fpc: fp,
              e_req: er, e_addr: ea, e_vld: ev, e_pc: ep};
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later, well before the rising edge.
    task automatic drive(input bit r, input bit rd, input bit iv, input logic [31:0] ii,
                         input bit p, input bit fl, input logic [31:0] fp);
        @(negedge clk);
        rst = r; rdy = rd; ic_valid = iv; ic_inst = ii; IQ_pop = p; flush = fl; flush_pc = fp;
        #1;
    endtask

    // Reference model: a plain queue plus "request outstanding" and "discard its response" flags.
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_drop;
    int          cd;

    initial begin
        rst = 1'b1; rdy = 1'b1; ic_valid = 1'b0; ic_inst = '0;
        IQ_pop = 1'b0; flush = 1'b0; flush_pc = '0;

        // Directed table: fill, full/resume, flush in WAIT, flush with response, rdy freeze.
        row(1,1,0,0,0,0,0, 0,0,0,0);
        for (int i = 0; i < DEPTH; i++) begin
            row(0,1,0,0,0,0,0,        1, 32'(4*i), (i > 0), 0);
            row(0,1,1,32'h13,0,0,0,   0, 32'(4*i), (i > 0), 0);
        end
        row(0,1,0,0,0,0,0, 0,0,1,0);
        row(0,1,0,0,1,0,0, 0,0,1,0);
        row(0,1,0,0,0,0,0, 1,64,1,4);
        row(0,1,1,32'h13,0,0,0, 0,64,1,4);
        row(0,1,0,0,0,0,0, 0,0,1,4);
        row(0,1,0,0,1,0,0, 0,0,1,4);
        row(0,1,0,0,0,0,0, 1,68,1,8);
        row(0,1,0,0,0,1,32'h100, 0,68,1,8);
        row(0,1,0,0,0,0,0, 0,0,0,0);
        row(0,1,0,0,0,0,0, 0,0,0,0);
        row(0,1,1,32'hdead,0,0,0, 0,0,0,0);
        row(0,1,0,0,0,0,0, 1,32'h100,0,0);
        row(0,1,1,32'h55,0,1,32'h200, 0,32'h100,0,0);
        row(0,1,0,0,0,0,0, 1,32'h200,0,0);
        row(0,1,1,32'h77,0,0,0, 0,32'h200,0,0);
        row(0,1,0,0,0,0,0, 1,32'h204,1,32'h200);
        row(0,0,0,0,1,0,0, 0,32'h204,1,32'h200);
        row(0,0,1,32'h99,1,0,0, 0,32'h204,1,32'h200);
        for (int i = 0; i < 3; i++) row(0,0,0,0,1,0,0, 0,0,1,32'h200);
        row(0,1,0,0,0,0,0, 1,32'h208,1,32'h200);
        row(0,1,0,0,1,0,0, 0,32'h208,1,32'h200);
        row(0,1,1,32'hab,0,0,0, 0,32'h208,1,32'h204);

        drive(1,1,0,0,0,0,0);
        drive(1,1,0,0,0,0,0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].iv, tbl[i].inst, tbl[i].pop, tbl[i].fl, tbl[i].fpc);
            check($sformatf("tbl%0d.ic_req", i),  {31'b0, ic_req},        {31'b0, tbl[i].e_req});
            check($sformatf("tbl%0d.ic_addr", i), ic_addr,                tbl[i].e_addr);
            check($sformatf("tbl%0d.valid", i),   {31'b0, IQ_inst_valid}, {31'b0, tbl[i].e_vld});
            check($sformatf("tbl%0d.IQ_pc", i),   IQ_pc,                  tbl[i].e_pc);
        end

        // Steady stream: 1-cycle ICache latency, pop every cycle, many pointer wraps.
        begin
            bit          prev_req;
            logic [31:0] exp_pc;
            int          n_seen;
            prev_req = 1'b0; exp_pc = RESET_PC; n_seen = 0;
            drive(1,1,0,0,0,0,0);
            drive(1,1,0,0,0,0,0);
            for (int c = 0; c < 200; c++) begin
                drive(0, 1, prev_req, $urandom, 1, 0, 0);
                if (IQ_inst_valid) begin
                    check("stream.IQ_pc", IQ_pc, exp_pc);
                    exp_pc += 4;
                    n_seen++;
                end
                prev_req = ic_req;
            end
            check("stream.count_gt_32", {31'b0, (n_seen > 32)}, 32'd1);
        end

        // Randomized traffic against the reference model.
        drive(1,1,0,0,0,0,0);
        mq.delete(); m_pc = RESET_PC; m_out = 0; m_drop = 0; cd = 0;
        for (int c = 0; c < 4000; c++) begin
            bit          r, rd, p, fl, iv, e_req;
            logic [31:0] fp, ii, e_addr;
            ent_t        e;
            r  = ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 9) != 0);
            p  = $urandom_range(0, 1) == 1;
            fl = ($urandom_range(0, 29) == 0);
            fp = ($urandom_range(0, 3) == 0) ? 32'hffff_fff0 : ($urandom & 32'hffff_fffc);
            ii = $urandom;
            iv = !r && m_out && (cd == 0);
            drive(r, rd, iv, ii, p, fl, fp);

            e_req  = !r && rd && !fl && !m_out && (mq.size() < DEPTH);
            e_addr = (e_req || (m_out && !m_drop)) ? m_pc : 32'h0;
            check("rnd.ic_req",  {31'b0, ic_req}, {31'b0, e_req});
            check("rnd.ic_addr", ic_addr, e_addr);
            check("rnd.valid",   {31'b0, IQ_inst_valid}, {31'b0, (mq.size() != 0)});
            check("rnd.IQ_inst", IQ_inst, (mq.size() != 0) ? mq[0].inst : 32'h0);
            check("rnd.IQ_pc",   IQ_pc,   (mq.size() != 0) ? mq[0].pc   : 32'h0);

            if (m_out && !iv && cd > 0) cd--;
            if (r) begin
                mq.delete(); m_pc = RESET_PC; m_out = 0; m_drop = 0;
            end else if (rd && fl) begin
                mq.delete();
                m_pc = fp;
                if (iv) begin
                    m_out = 0; m_drop = 0;
                end else if (m_out) begin
                    m_drop = 1;
                end
            end else begin
                if (rd && p && mq.size() != 0) void'(mq.pop_front());
                if (iv) begin
                    if (!m_drop) begin
                        e.inst = ii; e.pc = m_pc;
                        mq.push_back(e);
                        m_pc = m_pc + 32'd4;
                    end
                    m_out = 0; m_drop = 0;
                end
                if (e_req) begin
                    m_out = 1;
                    cd = $urandom_range(0, 2);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
